// File: rtl/upscaler_pkg.sv
// upscaler_pkg: shared types and kernel arithmetic for the upscaler smoothing stage.
package upscaler_pkg;
  localparam int CH_W = 8;
  localparam int ROUND = 8;
  localparam int SHIFT = 4;
  localparam int LATENCY = 2;
  localparam int KERN [3] = '{1, 2, 1};
  typedef logic [3*CH_W-1:0] rgb_t;
  typedef rgb_t [2:0] col_t;
  // Separable binomial weights: KERN[i]*KERN[j] gives [1 2 1; 2 4 2; 1 2 1].
  function automatic rgb_t kernel(input col_t [2:0] w);
    rgb_t r;
    logic [11:0] s;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 12'(ROUND);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s = s + 12'(KERN[i] * KERN[j]) * 12'(w[i][j][ch*CH_W +: CH_W]);
      r[ch*CH_W +: CH_W] = CH_W'(s >> SHIFT);
    end
    return r;
  endfunction
endpackage

// File: rtl/upscaler_line_buf.sv
// upscaler_line_buf: one-line RGB store, combinational read of the addressed column before the clocked write.
module upscaler_line_buf
  import upscaler_pkg::*;
#(
  parameter int DEPTH = 1152
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  rgb_t                     wdata_i,
  output rgb_t                     rdata_o
);
  rgb_t mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/upscaler.sv
// upscaler: causal 3x3 binomial smoothing of the replicated RGB stream, 2-cycle latency.
// UPSCALER_SMOOTH_EN enables the filter; without it the pixel is only delayed.
module upscaler
  import upscaler_pkg::*;
#(
  parameter int IMG_W = 384,
  parameter int IMG_H = 216,
  parameter int SCALE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        input_valid,
  output logic [23:0] pixel_out,
  output logic        output_valid
);
  logic [LATENCY-1:0] vld_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) vld_q <= '0;
    else vld_q <= {vld_q[LATENCY-2:0], input_valid};
  assign output_valid = vld_q[LATENCY-1];
`ifdef UPSCALER_SMOOTH_EN
  localparam int LINE_W = IMG_W * SCALE;
  localparam int LINE_H = IMG_H * SCALE;
  localparam int XW = $clog2(LINE_W);
  localparam int YW = $clog2(LINE_H);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  rgb_t row1, row2, r1, r2, out_q;
  col_t [2:0] win_q, win_d;
  upscaler_line_buf #(.DEPTH(LINE_W)) u_lb1 (
    .clk(clk), .we_i(input_valid), .addr_i(x_q), .wdata_i(pixel_in), .rdata_o(row1)
  );
  upscaler_line_buf #(.DEPTH(LINE_W)) u_lb2 (
    .clk(clk), .we_i(input_valid), .addr_i(x_q), .wdata_i(row1), .rdata_o(row2)
  );
  // Rows above the frame top and columns left of the line start clamp to row/column 0,
  // so buffer contents from a previous frame or power-up are never selected.
  always_comb begin
    x_d = (x_q == XW'(LINE_W - 1)) ? '0 : x_q + 1'b1;
    y_d = (x_q != XW'(LINE_W - 1)) ? y_q : (y_q == YW'(LINE_H - 1)) ? '0 : y_q + 1'b1;
    r1 = (y_q != '0) ? row1 : pixel_in;
    r2 = (y_q > YW'(1)) ? row2 : r1;
    win_d[0] = {r2, r1, pixel_in};
    win_d[1] = (x_q == '0) ? win_d[0] : win_q[0];
    win_d[2] = (x_q == '0) ? win_d[0] : (x_q == XW'(1)) ? win_q[0] : win_q[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      win_q <= '0;
      out_q <= '0;
    end else begin
      if (input_valid) begin
        x_q <= x_d;
        y_q <= y_d;
        win_q <= win_d;
      end
      if (vld_q[0]) out_q <= kernel(win_q);
    end
  assign pixel_out = out_q;
`else
  rgb_t [LATENCY-1:0] pipe_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pipe_q <= '0;
    else pipe_q <= {pipe_q[LATENCY-2:0], pixel_in};
  assign pixel_out = pipe_q[LATENCY-1];
`endif
endmodule

// File: tb/tb_upscaler.sv
// tb_upscaler: scoreboard bench for upscaler on a reduced 24x12 raster.
module tb_upscaler;
  localparam int IW = 8, IH = 4, SC = 3, LW = IW * SC, LH = IH * SC;
  logic clk = 1'b0, rst = 1'b1, input_valid = 1'b0, output_valid;
  logic [23:0] pixel_in = '0, pixel_out;
  int cyc = 0, checks = 0, passes = 0, fcnt = 0, f0 = 0, bx = 0, by = 0;
  logic [23:0] fr [LH][LW];
  typedef struct { logic [23:0] px; int due; } exp_t;
  exp_t sb[$];
  exp_t e;

  upscaler #(.IMG_W(IW), .IMG_H(IH), .SCALE(SC)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .input_valid(input_valid),
    .pixel_out(pixel_out), .output_valid(output_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %06h want %06h (cycle %0d)", nm, act, exp, cyc);
  endtask

`ifdef UPSCALER_SMOOTH_EN
  function automatic int kw(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic logic [23:0] ref_px(input int x, input int y);
    logic [23:0] r;
    int s;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 8;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          s += kw(dr) * kw(dc) * int'(fr[(y > dr) ? y - dr : 0][(x > dc) ? x - dc : 0][ch*8 +: 8]);
      r[ch*8 +: 8] = 8'(s / 16);
    end
    return r;
  endfunction
`endif

  task automatic push_drive(input logic [23:0] p, input logic [23:0] ex);
    sb.push_back('{ex, cyc + 2});
    pixel_in = p;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    bx = (bx == LW - 1) ? 0 : bx + 1;
    if (bx == 0) by = (by == LH - 1) ? 0 : by + 1;
  endtask

  task automatic send(input logic [23:0] p);
    fr[by][bx] = p;
`ifdef UPSCALER_SMOOTH_EN
    push_drive(p, ref_px(bx, by));
`else
    push_drive(p, p);
`endif
  endtask

  task automatic sendh(input logic [23:0] p, input logic [23:0] h);
    fr[by][bx] = p;
`ifdef UPSCALER_SMOOTH_EN
    push_drive(p, h);
`else
    push_drive(p, p + 24'(0 * h));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("output_missing_due_cycle", 24'(cyc), 24'(sb[0].due));
      void'(sb.pop_front());
    end
    if (output_valid) begin
      fcnt++;
      if (sb.size() == 0) chk("unexpected_output_valid", {23'd0, output_valid}, 24'd0);
      else begin
        e = sb.pop_front();
        chk("output_cycle", 24'(cyc), 24'(e.due));
        chk("output_pixel", pixel_out, e.px);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (12) begin
      @(negedge clk);
      chk("reset_pixel_out", pixel_out, 24'h000000);
      chk("reset_output_valid", {23'd0, output_valid}, 24'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    sendh(24'hFF0000, 24'hFF0000);
    send(24'h000000);
    send(24'h000000);
    sendh(24'hFFFFFF, 24'h404040);
    sendh(24'hFFFFFF, 24'hBFBFBF);
    sendh(24'hFFFFFF, 24'hFFFFFF);
    for (int x = 6; x < LW; x++) send(24'hFFFFFF);
    for (int y = 1; y < LH; y++)
      for (int x = 0; x < LW; x++) begin
        send({8'(x * 11 + y * 3), 8'(y * 19), 8'(x * x + y)});
        if ((x + y) % 7 == 0) idle(1 + x % 3);
      end
    idle(3);
    f0 = fcnt;
    for (int y = 0; y < LH; y++) begin
      for (int x = 0; x < LW; x++) sendh(24'h808080, 24'h808080);
      idle(1);
    end
    idle(3);
    chk("constant_frame_output_count", 24'(fcnt - f0), 24'(LW * LH));
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < LW; x++) send(24'($urandom));
    for (int x = 0; x < 5; x++) send(24'($urandom));
    rst = 1'b1;
    sb.delete();
    bx = 0;
    by = 0;
    #1;
    chk("midframe_reset_valid", {23'd0, output_valid}, 24'd0);
    chk("midframe_reset_pixel", pixel_out, 24'h000000);
    idle(2);
    rst = 1'b0;
    idle(2);
    sendh(24'h123456, 24'h123456);
    for (int x = 1; x < LW + 8; x++) begin
      send(24'($urandom));
      if (x % 5 == 0) idle(2);
    end
    idle(4);
    chk("scoreboard_drained", 24'(sb.size()), 24'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
